// File: rtl/binary_line_buffer3.sv
// binary_line_buffer3: turns a raster 1-bit pixel stream into three vertically aligned taps (rows r-2, r-1, r).
// Optional macro LINEBUF_ZERO_PAD_EN: taps start at row 0, and the missing rows above are padded with 0.
module binary_line_buffer3 #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frameStart,
  input  logic                          pixelIn,
  input  logic                          pixelValid,
  output logic                          tapTop,
  output logic                          tapMid,
  output logic                          tapBot,
  output logic                          tapValid,
  output logic [$clog2(IMG_WIDTH)-1:0]  tapCol,
  output logic [$clog2(IMG_HEIGHT)-1:0] tapRow,
  output logic                          frameDone
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [IMG_WIDTH-1:0] r_line1;
  logic [IMG_WIDTH-1:0] r_line2;
  logic [IMG_WIDTH-1:0] w_line1_shift;
  logic [IMG_WIDTH-1:0] w_line2_shift;

  logic             w_start;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last;
  logic             w_tap_valid;
  logic             w_frame_done;
  logic             w_top;
  logic             w_mid;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;

  // A frameStart pixel is always (0,0) of a new frame, whatever state we are in.
  assign w_start   = pixelValid && frameStart;
  assign w_accept  = w_start || (pixelValid && (r_state == FILL || r_state == STREAM));
  assign w_col     = w_start ? '0 : r_col;
  assign w_row     = w_start ? '0 : r_row;
  assign w_row_end = (w_col == COL_LAST);
  assign w_last    = w_row_end && (w_row == ROW_LAST);

  // Delay chain: line1 holds the previous row, line2 the row before that; tails are the same column.
  assign w_line1_shift[0] = pixelIn;
  assign w_line2_shift[0] = r_line1[IMG_WIDTH-1];
  generate
    for (genvar gi = 1; gi < IMG_WIDTH; gi++) begin : g_chain
      assign w_line1_shift[gi] = r_line1[gi-1];
      assign w_line2_shift[gi] = r_line2[gi-1];
    end
  endgenerate

`ifdef LINEBUF_ZERO_PAD_EN
  assign w_tap_valid = w_accept;
  assign w_top       = (w_row < ROW_W'(2)) ? 1'b0 : r_line2[IMG_WIDTH-1];
  assign w_mid       = (w_row == '0) ? 1'b0 : r_line1[IMG_WIDTH-1];
`else
  assign w_tap_valid = w_accept && !w_start && (r_state == STREAM);
  assign w_top       = r_line2[IMG_WIDTH-1];
  assign w_mid       = r_line1[IMG_WIDTH-1];
`endif

  assign w_frame_done = w_accept && !w_start && (r_state == STREAM) && w_last;

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = FILL;
    end else if (w_accept) begin
      if (r_state == FILL && w_row_end && w_row == ROW_FILL_LAST) begin
        w_state_next = STREAM;
      end else if (r_state == STREAM && w_last) begin
        w_state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_line1   <= '0;
      r_line2   <= '0;
      tapTop    <= 1'b0;
      tapMid    <= 1'b0;
      tapBot    <= 1'b0;
      tapValid  <= 1'b0;
      tapCol    <= '0;
      tapRow    <= '0;
      frameDone <= 1'b0;
    end else begin
      tapValid  <= w_tap_valid;
      frameDone <= w_frame_done;
      if (w_accept) begin
        r_line1 <= w_line1_shift;
        r_line2 <= w_line2_shift;
        tapTop  <= w_top;
        tapMid  <= w_mid;
        tapBot  <= pixelIn;
        tapCol  <= w_col;
        tapRow  <= w_row;
        if (w_row_end) begin
          r_col <= '0;
          r_row <= w_last ? '0 : w_row + ROW_W'(1);
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_line_buffer3.sv
// Directed bench for binary_line_buffer3 on a 4x4 image; one task per scenario, each with inline comparisons.
module tb_binary_line_buffer3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frameStart = 1'b0;
  logic       pixelIn = 1'b0;
  logic       pixelValid = 1'b0;
  logic       tapTop, tapMid, tapBot, tapValid, frameDone;
  logic [1:0] tapCol;
  logic [1:0] tapRow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_line_buffer3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .frameStart(frameStart), .pixelIn(pixelIn),
    .pixelValid(pixelValid), .tapTop(tapTop), .tapMid(tapMid), .tapBot(tapBot),
    .tapValid(tapValid), .tapCol(tapCol), .tapRow(tapRow), .frameDone(frameDone)
  );

  // Drives one cycle of input; returns 1 time unit after the edge, when the registered outputs are settled.
  task automatic step(input logic v, input logic fs, input logic p);
    pixelValid = v;
    frameStart = fs;
    pixelIn    = p;
    @(posedge clk);
    #1;
    pixelValid = 1'b0;
    frameStart = 1'b0;
    pixelIn    = 1'b0;
    if (tapValid === 1'b1)
      $display("tap row=%0d col=%0d top=%b mid=%b bot=%b done=%b", tapRow, tapCol, tapTop, tapMid, tapBot, frameDone);
  endtask

  // Reference taps for raster index k (row >= 2) of a 4x4 image, bit k = pixel (k/4, k%4).
  function automatic logic [2:0] taps_of(input logic [15:0] img, input int k);
    return {img[k-8], img[k-4], img[k]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if ({tapTop, tapMid, tapBot, tapValid, frameDone, tapCol, tapRow} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {tapTop, tapMid, tapBot, tapValid, frameDone, tapCol, tapRow}, 9'd0);
    end
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (tapValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ignores got=%b exp=0", tapValid);
    end
  endtask

`ifndef LINEBUF_ZERO_PAD_EN
  task automatic test_back_to_back();
    logic [15:0] img;
    int n_valid;
    img = 16'hAAAA;
    n_valid = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, img[k]);
      checks++;
      if (tapValid !== (k >= 8)) begin
        errors++;
        $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, tapValid, k >= 8);
      end
      checks++;
      if (frameDone !== (k == 15)) begin
        errors++;
        $display("FAIL b2b_done k=%0d got=%b exp=%b", k, frameDone, k == 15);
      end
      if (k >= 8) begin
        n_valid++;
        checks++;
        if ({tapTop, tapMid, tapBot} !== taps_of(img, k)) begin
          errors++;
          $display("FAIL b2b_taps k=%0d got=%b exp=%b", k, {tapTop, tapMid, tapBot}, taps_of(img, k));
        end
        checks++;
        if ({tapRow, tapCol} !== 4'(k)) begin
          errors++;
          $display("FAIL b2b_pos k=%0d got=%0d exp=%0d", k, {tapRow, tapCol}, k);
        end
      end
    end
    checks++;
    if (n_valid !== 8) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=8", n_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if ({tapValid, frameDone} !== 2'b00) begin
        errors++;
        $display("FAIL done_ignores k=%0d got=%b exp=00", k, {tapValid, frameDone});
      end
    end
  endtask

  task automatic test_single_ink();
    logic [15:0] img;
    img = 16'h0040;  // ink only at (1,2)
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, img[k]);
      if (k >= 8) begin
        checks++;
        if (tapValid !== 1'b1 || {tapTop, tapMid, tapBot} !== taps_of(img, k)) begin
          errors++;
          $display("FAIL ink_taps k=%0d got=%b%b exp=1%b", k, tapValid, {tapTop, tapMid, tapBot}, taps_of(img, k));
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic [15:0] img;
    int n_valid;
    img = 16'hC963;
    n_valid = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, img[k]);
      checks++;
      if (tapValid !== (k >= 8) || frameDone !== (k == 15)) begin
        errors++;
        $display("FAIL gap_valid k=%0d got=%b%b exp=%b%b", k, tapValid, frameDone, k >= 8, k == 15);
      end
      if (k >= 8) begin
        n_valid++;
        checks++;
        if ({tapTop, tapMid, tapBot} !== taps_of(img, k) || {tapRow, tapCol} !== 4'(k)) begin
          errors++;
          $display("FAIL gap_taps k=%0d got=%b pos=%0d exp=%b pos=%0d", k, {tapTop, tapMid, tapBot},
                   {tapRow, tapCol}, taps_of(img, k), k);
        end
      end
      // frameStart without pixelValid in the idle cycle must be ignored
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if ({tapValid, frameDone} !== 2'b00) begin
        errors++;
        $display("FAIL gap_idle k=%0d got=%b exp=00", k, {tapValid, frameDone});
      end
    end
    checks++;
    if (n_valid !== 8) begin
      errors++;
      $display("FAIL gap_count got=%0d exp=8", n_valid);
    end
  endtask

  task automatic test_abort();
    logic [15:0] img;
    int n_valid;
    img = 16'hC963;
    n_valid = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, k == 0, 1'b1);
      checks++;
      if ({tapValid, frameDone} !== 2'b00) begin
        errors++;
        $display("FAIL abort_a k=%0d got=%b exp=00", k, {tapValid, frameDone});
      end
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, img[k]);
      checks++;
      if (tapValid !== (k >= 8) || frameDone !== (k == 15)) begin
        errors++;
        $display("FAIL abort_valid k=%0d got=%b%b exp=%b%b", k, tapValid, frameDone, k >= 8, k == 15);
      end
      if (k >= 8) begin
        n_valid++;
        checks++;
        if ({tapTop, tapMid, tapBot} !== taps_of(img, k) || {tapRow, tapCol} !== 4'(k)) begin
          errors++;
          $display("FAIL abort_taps k=%0d got=%b pos=%0d exp=%b pos=%0d", k, {tapTop, tapMid, tapBot},
                   {tapRow, tapCol}, taps_of(img, k), k);
        end
      end
    end
    checks++;
    if (n_valid !== 8) begin
      errors++;
      $display("FAIL abort_count got=%0d exp=8", n_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n_valid;
    n_valid = 0;
    for (int k = 0; k < 10; k++) step(1'b1, k == 0, 1'b1);
    checks++;
    if ({tapValid, tapTop, tapMid, tapBot} !== 4'b1111) begin
      errors++;
      $display("FAIL mid_stream_setup got=%b exp=1111", {tapValid, tapTop, tapMid, tapBot});
    end
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    checks++;
    if ({tapTop, tapMid, tapBot, tapValid, frameDone, tapCol, tapRow} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b exp=%b", {tapTop, tapMid, tapBot, tapValid, frameDone, tapCol, tapRow}, 9'd0);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1);
      if (tapValid !== 1'b0 || frameDone !== 1'b0) n_valid++;
    end
    checks++;
    if (n_valid !== 0) begin
      errors++;
      $display("FAIL post_reset_no_taps got=%0d exp=0", n_valid);
    end
  endtask
`else
  task automatic test_zero_pad();
    int n_valid;
    int r;
    logic [2:0] exp_taps;
    n_valid = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, 1'b1);
      r = k / 4;
      exp_taps = {r >= 2, r >= 1, 1'b1};
      if (tapValid === 1'b1) n_valid++;
      checks++;
      if (tapValid !== 1'b1 || frameDone !== (k == 15)) begin
        errors++;
        $display("FAIL zpad_valid k=%0d got=%b%b exp=1%b", k, tapValid, frameDone, k == 15);
      end
      checks++;
      if ({tapTop, tapMid, tapBot} !== exp_taps || {tapRow, tapCol} !== 4'(k)) begin
        errors++;
        $display("FAIL zpad_taps k=%0d got=%b pos=%0d exp=%b pos=%0d", k, {tapTop, tapMid, tapBot},
                 {tapRow, tapCol}, exp_taps, k);
      end
    end
    checks++;
    if (n_valid !== 16) begin
      errors++;
      $display("FAIL zpad_count got=%0d exp=16", n_valid);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
`ifndef LINEBUF_ZERO_PAD_EN
    test_back_to_back();
    test_single_ink();
    test_gapped();
    test_abort();
    test_reset_mid_stream();
`else
    test_zero_pad();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
